bloom_filter_ctrl: RTL and testbench
====================================

# bloom_filter_ctrl

Arbitrated controller for the folding XOR-multiply hash feeding a Bloom-filter bit array. Accepts insert/query requests from `NumReq` requesters, grants one at a time round-robin, and computes the hash iteratively one `HashWidth` chunk per cycle. It then sets or tests the indexed bit and returns a single-cycle response. It sits between the requesting units and the filter storage, which it owns.

## Interface
- `NumReq`, 2: requester count (≥2).
- `DataWidth`, 32: key width; must be a multiple of `HashWidth`.
- `HashWidth`, 8: hash/accumulator width.
- `BlSize`, 256: filter bits; power of two, ≤ 2^`HashWidth`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active low.
- `req_i` in `NumReq`: request per requester; held until granted.
- `op_i` in `NumReq`: 1 = insert, 0 = query, per requester.
- `data_i` in `NumReq`×`DataWidth`: key per requester.
- `gnt_o` out `NumReq`: one-hot, one-cycle grant; key and op are captured that cycle.
- `rsp_valid_o` out 1: one-cycle response strobe.
- `rsp_id_o` out `$clog2(NumReq)`: requester being answered.
- `rsp_hit_o` out 1: indexed bit value before the update.
- `rsp_hash_o` out `HashWidth`: final hash.
- `busy_o` out 1: FSM not in IDLE.
- `stat_ins_o`, `stat_qry_o`, `stat_hit_o` out 16 each: counters (see Configuration).

## Operation
- FSM states:
  - IDLE: if any `req_i` is high, grant the winner, capture its key/op/id, set acc = 31 and chunk = 0, and go to HASH. Otherwise stay in IDLE.
  - HASH: acc = ((acc ^ key[chunk*HashWidth +: HashWidth]) * 17) mod 2^HashWidth. Chunk 0 is the LSBs. Chunk increments each cycle. After chunk `DataWidth/HashWidth-1` is processed, go to UPDATE.
  - UPDATE: idx = acc[$clog2(BlSize)-1:0]. rsp_hit = bit[idx]. If the op is insert, set bit[idx] = 1. Pulse `rsp_valid_o` and drive id/hash. Go to IDLE.
- Arbitration is round-robin. The search starts at last_grant+1 and wraps. After reset, last_grant = `NumReq`-1, so requester 0 wins first.
- Requests are not granted while busy. A requester must not drop `req_i` before its grant.
- `rsp_hit_o`, `rsp_id_o` and `rsp_hash_o` hold their last values between strobes.
- Reset (asynchronous, any state):
  - all filter bits are cleared;
  - FSM returns to IDLE and any in-flight request is dropped with no response;
  - all outputs go to 0 and all counters go to 0;
  - last_grant returns to `NumReq`-1.

## Timing
- Grant in cycle T.
- HASH occupies T+1 … T+C, where C = `DataWidth/HashWidth`.
- `rsp_valid_o` is high in T+C+1.
- The next grant comes no earlier than T+C+2. Throughput is one request per C+2 cycles.
- Back-to-back insert then query of the same key: the query observes the set bit.

## Configuration
- `BLOOM_FILTER_STATS_EN` defined:
  - `stat_ins_o` counts inserts at UPDATE;
  - `stat_qry_o` counts queries at UPDATE;
  - `stat_hit_o` counts queries with hit = 1.
  - All three saturate at 0xFFFF and reset to 0.
- `BLOOM_FILTER_STATS_EN` undefined: the counters are not built and all three ports are tied to 0.

## Structure
- `bloom_pkg`:
  - `bloom_op_e` (QUERY = 0, INSERT = 1);
  - `bloom_state_e` (IDLE, HASH, UPDATE);
  - `HASH_SEED` = 31;
  - `HASH_MULT` = 17.
- Sub-module `bloom_hash_iter`: the accumulator, chunk counter and chunk mux. It has start/step/done ports. The arbiter, FSM and bit array stay in the top level.

## Test plan
- Insert key 0x00000000 from requester 0 at T (params default):
  - `gnt_o` = 01 at T;
  - `rsp_valid_o` at T+5 with id 0, hash 0xDF, hit 0.
- Query 0x00000000 from requester 1 after that insert:
  - hit 1, hash 0xDF.
- Query 0x00000001 on a filter holding only 0x00000000:
  - hash 0x9E, hit 0.
- `req_i` = 11 held continuously with different keys:
  - grants alternate 01, 10, 01, … spaced 6 cycles;
  - `rsp_id_o` alternates 0, 1, 0.
- Assert `rst_ni` low during HASH, then release:
  - no response;
  - `busy_o` = 0;
  - a later query of the earlier inserted key returns hit 0.
- With `BLOOM_FILTER_STATS_EN`:
  - 2 inserts and 3 queries (2 hits) give counters 2, 3, 2.
  - Without the macro, all three counters read 0.

Source files
------------

// File: rtl/bloom_pkg.sv
// ============================================================================
// Module  : bloom_pkg
// Brief   : Shared types and hash constants for the Bloom-filter controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bloom_pkg;

   typedef enum logic {
      QUERY  = 1'b0,
      INSERT = 1'b1
   } bloom_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HASH   = 2'd1,
      UPDATE = 2'd2
   } bloom_state_e;

   localparam int HASH_SEED = 31;
   localparam int HASH_MULT = 17;

endpackage

`default_nettype wire

// File: rtl/bloom_filter_ctrl_if.sv
// ============================================================================
// Module  : bloom_filter_ctrl_if
// Brief   : Requester-side request/grant and response bundle of the controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bloom_filter_ctrl_if #(
   parameter int NumReq    = 2,
   parameter int DataWidth = 32,
   parameter int HashWidth = 8
);
   logic [NumReq-1:0]                 req_i;
   logic [NumReq-1:0]                 op_i;
   logic [NumReq-1:0][DataWidth-1:0]  data_i;
   logic [NumReq-1:0]                 gnt_o;
   logic                              rsp_valid_o;
   logic [$clog2(NumReq)-1:0]         rsp_id_o;
   logic                              rsp_hit_o;
   logic [HashWidth-1:0]              rsp_hash_o;
   logic                              busy_o;
   logic [15:0]                       stat_ins_o;
   logic [15:0]                       stat_qry_o;
   logic [15:0]                       stat_hit_o;

   modport master (
      output req_i, op_i, data_i,
      input  gnt_o, rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_hash_o, busy_o,
      input  stat_ins_o, stat_qry_o, stat_hit_o
   );

   modport slave (
      input  req_i, op_i, data_i,
      output gnt_o, rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_hash_o, busy_o,
      output stat_ins_o, stat_qry_o, stat_hit_o
   );

endinterface

`default_nettype wire

// File: rtl/bloom_hash_iter.sv
// ============================================================================
// Module  : bloom_hash_iter
// Brief   : Iterative folding XOR-multiply hash, one HashWidth chunk per step.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bloom_hash_iter
   import bloom_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int HashWidth = 8
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   input  wire logic                 start,
   input  wire logic                 step,
   input  wire logic [DataWidth-1:0] key,
   output logic      [HashWidth-1:0] acc_next,
   output logic                      done
);

   localparam int C  = DataWidth / HashWidth;
   localparam int CW = (C > 1) ? $clog2(C) : 1;

   logic [HashWidth-1:0] r_acc;
   logic [CW-1:0]        r_chunk;
   logic [HashWidth-1:0] w_mix;

   // Chunk 0 is the least significant slice of the key.
   assign w_mix    = r_acc ^ key[int'(r_chunk)*HashWidth +: HashWidth];
   assign acc_next = w_mix * HashWidth'(HASH_MULT);
   assign done     = (r_chunk == CW'(C - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_chunk <= '0;
      end else if (start) begin
         r_acc   <= HashWidth'(HASH_SEED);
         r_chunk <= '0;
      end else if (step) begin
         r_acc   <= acc_next;
         r_chunk <= r_chunk + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/bloom_filter_ctrl.sv
// ============================================================================
// Module  : bloom_filter_ctrl
// Brief   : Round-robin arbitrated insert/query controller owning a Bloom bit
//           array; optional counters enabled by BLOOM_FILTER_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bloom_filter_ctrl
   import bloom_pkg::*;
#(
   parameter int NumReq    = 2,
   parameter int DataWidth = 32,
   parameter int HashWidth = 8,
   parameter int BlSize    = 256
) (
   input  wire logic          clk_i,
   input  wire logic          rst_ni,
   bloom_filter_ctrl_if.slave bus
);

   localparam int IdW  = $clog2(NumReq);
   localparam int IdxW = $clog2(BlSize);

   bloom_state_e          r_state;
   logic [IdW-1:0]        r_last;
   logic [IdW-1:0]        r_id;
   logic [DataWidth-1:0]  r_key;
   bloom_op_e             r_op;
   logic                  r_rsp_valid;
   logic                  r_rsp_hit;
   logic [HashWidth-1:0]  r_rsp_hash;
   logic [IdW-1:0]        r_rsp_id;
   logic [BlSize-1:0]     r_bits;

   logic [IdW-1:0]        w_win;
   logic                  w_any;
   logic                  w_start;
   logic                  w_step;
   logic                  w_done;
   logic                  w_commit;
   logic [HashWidth-1:0]  w_acc_next;
   logic [IdxW-1:0]       w_idx;
   logic [NumReq-1:0]     w_gnt;

   // Scans from farthest to nearest so the requester right after last wins.
   function automatic logic [IdW-1:0] f_rr_pick(input logic [NumReq-1:0] req,
                                                input logic [IdW-1:0]    last);
      logic [IdW-1:0] win;
      int             cand;
      win = last;
      for (int k = NumReq; k >= 1; k--) begin
         cand = (int'(last) + k) % NumReq;
         if (req[cand]) win = IdW'(cand);
      end
      return win;
   endfunction

   assign w_any    = |bus.req_i;
   assign w_win    = f_rr_pick(bus.req_i, r_last);
   assign w_start  = (r_state == IDLE) && w_any;
   assign w_step   = (r_state == HASH);
   assign w_commit = w_step && w_done;
   assign w_idx    = w_acc_next[IdxW-1:0];

   always_comb begin
      w_gnt = '0;
      if (w_start && rst_ni) w_gnt[w_win] = 1'b1;
   end

   bloom_hash_iter #(
      .DataWidth (DataWidth),
      .HashWidth (HashWidth)
   ) u_hash (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .start    (w_start),
      .step     (w_step),
      .key      (r_key),
      .acc_next (w_acc_next),
      .done     (w_done)
   );

   // The final hash and lookup are registered on the last HASH edge so the
   // response is already stable for the whole UPDATE cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_last      <= IdW'(NumReq - 1);
         r_id        <= '0;
         r_key       <= '0;
         r_op        <= QUERY;
         r_rsp_valid <= 1'b0;
         r_rsp_hit   <= 1'b0;
         r_rsp_hash  <= '0;
         r_rsp_id    <= '0;
         r_bits      <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_key   <= bus.data_i[w_win];
                  r_op    <= bloom_op_e'(bus.op_i[w_win]);
                  r_id    <= w_win;
                  r_last  <= w_win;
                  r_state <= HASH;
               end
            end
            HASH: begin
               if (w_done) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_hit   <= r_bits[w_idx];
                  r_rsp_hash  <= w_acc_next;
                  r_rsp_id    <= r_id;
                  if (r_op == INSERT) r_bits[w_idx] <= 1'b1;
                  r_state     <= UPDATE;
               end
            end
            UPDATE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt_o       = w_gnt;
   assign bus.rsp_valid_o = r_rsp_valid;
   assign bus.rsp_hit_o   = r_rsp_hit;
   assign bus.rsp_hash_o  = r_rsp_hash;
   assign bus.rsp_id_o    = r_rsp_id;
   assign bus.busy_o      = (r_state != IDLE);

`ifdef BLOOM_FILTER_STATS_EN
   logic [15:0] r_stat_ins;
   logic [15:0] r_stat_qry;
   logic [15:0] r_stat_hit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stat_ins <= '0;
         r_stat_qry <= '0;
         r_stat_hit <= '0;
      end else if (w_commit) begin
         if (r_op == INSERT) begin
            if (r_stat_ins != 16'hFFFF) r_stat_ins <= r_stat_ins + 16'd1;
         end else begin
            if (r_stat_qry != 16'hFFFF) r_stat_qry <= r_stat_qry + 16'd1;
            if (r_bits[w_idx] && (r_stat_hit != 16'hFFFF))
               r_stat_hit <= r_stat_hit + 16'd1;
         end
      end
   end

   assign bus.stat_ins_o = r_stat_ins;
   assign bus.stat_qry_o = r_stat_qry;
   assign bus.stat_hit_o = r_stat_hit;
`else
   assign bus.stat_ins_o = '0;
   assign bus.stat_qry_o = '0;
   assign bus.stat_hit_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bloom_filter_ctrl.sv
// ============================================================================
// Module  : tb_bloom_filter_ctrl
// Brief   : Directed scoreboard bench for bloom_filter_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bloom_filter_ctrl;
   import bloom_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   typedef struct {
      int         id;
      logic [7:0] hash;
      logic       hit;
      int         gcyc;
   } exp_t;

   exp_t         q[$];
   logic [255:0] mbits;

   bloom_filter_ctrl_if #(.NumReq(2), .DataWidth(32), .HashWidth(8)) bus ();

   bloom_filter_ctrl #(
      .NumReq    (2),
      .DataWidth (32),
      .HashWidth (8),
      .BlSize    (256)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   function automatic logic [7:0] mhash(input logic [31:0] k);
      logic [7:0] a;
      a = 8'd31;
      for (int i = 0; i < 4; i++) a = 8'((a ^ k[i*8 +: 8]) * 8'd17);
      return a;
   endfunction

   // Response monitor: pops one expectation per strobe
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && bus.rsp_valid_o) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d hash 0x%0h, expected no response",
                     bus.rsp_id_o, bus.rsp_hash_o);
         end else begin
            e = q.pop_front();
            chk("rsp_id", 32'(bus.rsp_id_o), 32'(e.id));
            chk("rsp_hash", 32'(bus.rsp_hash_o), 32'(e.hash));
            chk("rsp_hit", 32'(bus.rsp_hit_o), 32'(e.hit));
            chk("rsp_latency", 32'(cyc - e.gcyc), 32'd5);
         end
      end
   end

   task automatic wait_grant(input logic [1:0] want, output int gc, output bit ok);
      ok = 1'b0;
      gc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.gnt_o != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL gnt_timeout: got no grant, expected 0x%0h", want);
      end else begin
         chk("gnt", 32'(bus.gnt_o), 32'(want));
         gc = cyc;
      end
   endtask

   task automatic issue(input int id, input logic op, input logic [31:0] key,
                        input bit push, input logic [7:0] eh, input logic ehit);
      int         gc;
      bit         ok;
      logic [1:0] eg;
      @(posedge clk); #1;
      bus.op_i[id]   = op;
      bus.data_i[id] = key;
      bus.req_i[id]  = 1'b1;
      eg     = '0;
      eg[id] = 1'b1;
      wait_grant(eg, gc, ok);
      if (ok && push) begin
         q.push_back('{id, eh, ehit, gc});
         if (op) mbits[eh] = 1'b1;
      end
      @(posedge clk); #1;
      bus.req_i[id] = 1'b0;
   endtask

   task automatic run_dual(input int n, input logic op0, input logic op1,
                           input logic [31:0] ka0, input logic [31:0] ka1,
                           input logic [31:0] kb0, input logic [31:0] kb1);
      int          gc, prev, id;
      bit          ok;
      logic [1:0]  eg;
      logic [7:0]  h;
      @(posedge clk); #1;
      bus.op_i      = {op1, op0};
      bus.data_i[0] = ka0;
      bus.data_i[1] = kb0;
      bus.req_i     = 2'b11;
      prev          = 0;
      for (int g = 0; g < n; g++) begin
         id     = g % 2;
         eg     = '0;
         eg[id] = 1'b1;
         wait_grant(eg, gc, ok);
         if (!ok) break;
         if (g > 0) chk("gnt_spacing", 32'(gc - prev), 32'd6);
         prev = gc;
         h = mhash(bus.data_i[id]);
         q.push_back('{id, h, mbits[h], gc});
         if (bus.op_i[id]) mbits[h] = 1'b1;
         @(posedge clk); #1;
         if (id == 0) bus.data_i[0] = ka1;
         else         bus.data_i[1] = kb1;
         if (g + 2 >= n) bus.req_i[id] = 1'b0;
      end
      bus.req_i = '0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !bus.busy_o) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: got %0d pending responses, expected 0", q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] h;
      bus.req_i  = 2'b11;
      bus.op_i   = '0;
      bus.data_i = '0;
      mbits      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("rst_hash", 32'(bus.rsp_hash_o), 32'd0);
      chk("rst_stat_ins", 32'(bus.stat_ins_o), 32'd0);
      bus.req_i = '0;
      rst_n     = 1'b1;

      // Hand-computed hashes: key 0 -> 0xDF, key 1 -> 0x9E
      issue(0, 1'b1, 32'h0000_0000, 1'b1, 8'hDF, 1'b0);
      issue(1, 1'b0, 32'h0000_0000, 1'b1, 8'hDF, 1'b1);
      issue(1, 1'b0, 32'h0000_0001, 1'b1, 8'h9E, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("hold_hash", 32'(bus.rsp_hash_o), 32'h9E);
      chk("hold_id", 32'(bus.rsp_id_o), 32'd1);
      chk("hold_valid", 32'(bus.rsp_valid_o), 32'd0);

      run_dual(4, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_00FF, 32'h1234_5678, 32'hDEAD_BEEF);
      wait_idle();

      h = mhash(32'hCAFE_F00D);
      issue(0, 1'b1, 32'hCAFE_F00D, 1'b1, h, mbits[h]);
      wait_idle();

      // Abort an insert mid-HASH with an asynchronous reset
      issue(0, 1'b1, 32'h55AA_55AA, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy_o), 32'd0);
      chk("abort_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("abort_hash", 32'(bus.rsp_hash_o), 32'd0);
      chk("abort_id", 32'(bus.rsp_id_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mbits = '0;
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_busy", 32'(bus.busy_o), 32'd0);

      run_dual(2, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0, 32'h0000_0000, 32'h0);
      issue(0, 1'b1, 32'h0000_0001, 1'b1, 8'h9E, 1'b0);
      issue(1, 1'b0, 32'h0000_0000, 1'b1, 8'hDF, 1'b1);
      issue(0, 1'b0, 32'h0000_0001, 1'b1, 8'h9E, 1'b1);
      wait_idle();

`ifdef BLOOM_FILTER_STATS_EN
      chk("stat_ins", 32'(bus.stat_ins_o), 32'd2);
      chk("stat_qry", 32'(bus.stat_qry_o), 32'd3);
      chk("stat_hit", 32'(bus.stat_hit_o), 32'd2);
`else
      chk("stat_ins", 32'(bus.stat_ins_o), 32'd0);
      chk("stat_qry", 32'(bus.stat_qry_o), 32'd0);
      chk("stat_hit", 32'(bus.stat_hit_o), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
